// File: rtl/fp_cust_issuer.sv
// Initiator side of the multicycle FP custom-instruction interface.
// Takes commands from a valid/ready stream, runs the slave handshake with a watchdog, and returns the result.
module fp_cust_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [1:0]  ADD_OPCODE     = 2'd0,
  parameter logic [1:0]  SUB_OPCODE     = 2'd1,
  parameter logic [1:0]  MUL_OPCODE     = 2'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] ci_dataa,
  output logic [31:0] ci_datab,
  output logic [1:0]  ci_n,
  output logic        ci_start,
  output logic        ci_clk_en,
  input  logic [31:0] ci_result,
  input  logic        ci_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [4:0] TIMEOUT_VAL = 5'(TIMEOUT_CYCLES);
  localparam logic [4:0] TIMER_MAX   = 5'h1F;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_dataa;
  logic [31:0] r_datab;
  logic [1:0]  r_n;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic [4:0]  r_timer;
  logic [4:0]  w_timer_inc;
  logic        w_op_legal;
  logic        w_cmd_hs;
  logic        w_timeout;

  assign w_op_legal  = (cmd_op == ADD_OPCODE) || (cmd_op == SUB_OPCODE) || (cmd_op == MUL_OPCODE);
  assign w_cmd_hs    = cmd_valid && (r_state == S_IDLE);
  assign w_timeout   = (r_timer >= TIMEOUT_VAL);
  assign w_timer_inc = (r_timer == TIMER_MAX) ? r_timer : r_timer + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    ci_start    = 1'b0;
    ci_clk_en   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (w_cmd_hs) begin
          w_state_nxt = w_op_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        ci_start    = 1'b1;
        ci_clk_en   = 1'b1;
        w_state_nxt = ci_done ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        ci_clk_en = 1'b1;
        if (ci_done || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands stay on the slave bus after capture until the next command replaces them.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dataa    <= '0;
      r_datab    <= '0;
      r_n        <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_timer    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_n     <= cmd_op;
            r_dataa <= cmd_a;
            r_datab <= cmd_b;
            r_timer <= 5'd1;
            if (!w_op_legal) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (ci_done) begin
            r_rsp_data <= ci_result;
            r_rsp_err  <= 1'b0;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_WAIT: begin
          // A done arriving in the timeout cycle still wins.
          if (ci_done) begin
            r_rsp_data <= ci_result;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign ci_dataa = r_dataa;
  assign ci_datab = r_datab;
  assign ci_n     = r_n;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_fp_cust_issuer.sv
// Directed bench for fp_cust_issuer with a behavioural custom-instruction slave.
// The slave pulses done a programmable number of cycles after start, or never.
module tb_fp_cust_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic [1:0]  ci_n;
  logic        ci_start;
  logic        ci_clk_en;
  logic [31:0] ci_result;
  logic        ci_done;

  int          n_checks = 0;
  int          n_fails  = 0;

  // Slave model controls: latency -1 means done is never asserted.
  int          slave_lat = -1;
  logic [31:0] slave_res = '0;
  logic        spur_done = 1'b0;
  int          slave_cnt = 0;
  logic        slave_act = 1'b0;

  fp_cust_issuer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .ci_dataa  (ci_dataa),
    .ci_datab  (ci_datab),
    .ci_n      (ci_n),
    .ci_start  (ci_start),
    .ci_clk_en (ci_clk_en),
    .ci_result (ci_result),
    .ci_done   (ci_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ci_done = spur_done;
    if (reset) begin
      slave_act = 1'b0;
      slave_cnt = 0;
    end else begin
      if (ci_start) begin
        slave_act = 1'b1;
        slave_cnt = 0;
      end else if (slave_act) begin
        slave_cnt++;
      end
      if (slave_act && slave_lat >= 0 && slave_cnt == slave_lat) begin
        ci_done   = 1'b1;
        ci_result = slave_res;
        slave_act = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] res,
                         input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                         input int hold);
    int   seen;
    int   starts;
    logic legal;
    legal     = (op != 2'd3);
    slave_lat = lat;
    slave_res = res;
    @(negedge clk);
    check({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    seen      = -1;
    starts    = 0;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) @(negedge clk);
      if (ci_start) starts++;
      if (i == 0 && legal) begin
        check({tag, " issue n"}, 32'(ci_n), 32'(op));
        check({tag, " issue dataa"}, ci_dataa, a);
        check({tag, " issue datab"}, ci_datab, b);
        check({tag, " issue clk_en"}, 32'(ci_clk_en), 32'd1);
        check({tag, " issue cmd_ready"}, 32'(cmd_ready), 32'd0);
      end
      if (rsp_valid) begin
        seen = i;
        break;
      end
    end
    check({tag, " rsp latency"}, 32'(seen), 32'(exp_lat));
    check({tag, " start pulses"}, 32'(starts), legal ? 32'd1 : 32'd0);
    check({tag, " rsp_data"}, rsp_data, exp_data);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, " dataa held"}, ci_dataa, a);
    check({tag, " clk_en in resp"}, 32'(ci_clk_en), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold rsp_data"}, rsp_data, exp_data);
      check({tag, " hold cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " post busy"}, 32'(busy), 32'd0);
    check({tag, " post cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int rsp_seen;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    ci_done   = 1'b0;
    ci_result = '0;
    repeat (2) @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset ctrl", {26'd0, rsp_valid, rsp_err, busy, ci_start, ci_clk_en, ci_n != 2'd0}, 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset dataa", ci_dataa, 32'd0);
    reset = 1'b0;

    // 1.0 + 2.0 = 3.0, slave latency 7, response held off for 5 cycles
    run_cmd("add", 2'd0, 32'h3F80_0000, 32'h4000_0000, 7, 32'h4040_0000, 8, 32'h4040_0000, 1'b0, 5);
    // inf * 0 via the slave's same-cycle special-value path
    run_cmd("mul", 2'd2, 32'h7F80_0000, 32'h0000_0000, 0, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 1'b0, 0);
    // Illegal opcode: straight to an error response, slave untouched
    run_cmd("ill", 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'h5555_5555, 0, 32'h0, 1'b1, 2);

    // Spurious done pulses while idle must not start anything
    spur_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur idle busy", 32'(busy), 32'd0);
      check("spur idle rsp_valid", 32'(rsp_valid), 32'd0);
    end
    spur_done = 1'b0;

    run_cmd("timeout", 2'd0, 32'h3F80_0000, 32'h3F80_0000, -1, 32'hDEAD_BEEF, 16, 32'h0, 1'b1, 0);
    // 1.5 - 1.0 = 0.5: done lands in the timeout cycle and wins
    run_cmd("coincide", 2'd1, 32'h3FC0_0000, 32'h3F80_0000, 15, 32'h3F00_0000, 16, 32'h3F00_0000, 1'b0, 0);
    run_cmd("late", 2'd1, 32'h3FC0_0000, 32'h3F80_0000, 16, 32'h3F00_0000, 16, 32'h0, 1'b1, 0);
    run_cmd("lat14", 2'd2, 32'h4000_0000, 32'h4040_0000, 14, 32'h40C0_0000, 15, 32'h40C0_0000, 1'b0, 1);

    // Reset in the middle of a wait drops the command without a response
    slave_lat = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_a     = 32'h4120_0000;
    cmd_b     = 32'h4120_0000;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset clk_en", 32'(ci_clk_en), 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid reset ctrl", {26'd0, rsp_valid, rsp_err, busy, ci_start, ci_clk_en, ci_n != 2'd0}, 32'd0);
    check("mid reset rsp_data", rsp_data, 32'd0);
    check("mid reset dataa", ci_dataa, 32'd0);
    check("mid reset datab", ci_datab, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    rsp_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || busy) rsp_seen++;
    end
    check("no rsp after reset", 32'(rsp_seen), 32'd0);

    // 2.0 + 2.0 = 4.0 after recovery
    run_cmd("recover", 2'd0, 32'h4000_0000, 32'h4000_0000, 2, 32'h4080_0000, 3, 32'h4080_0000, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
